// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: CTRL/STATUS/TXDATA/RXDATA registers, TX and RX FIFOs,
// runtime baud divisor and sticky overrun / framing-error flags.
module uart_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [15:0] r_div;
    logic        r_tx_en, r_rx_en, r_overrun, r_frame_err;
    logic [7:0]  r_tx_mem [FIFO_DEPTH];
    logic [7:0]  r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    tx_state_t   r_tx_state, w_tx_state_next;
    rx_state_t   r_rx_state, w_rx_state_next;
    logic [15:0] r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
    logic [2:0]  r_tx_bit, r_rx_bit;
    logic [7:0]  r_tx_shift, r_rx_shift;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;

    logic [2:0]    w_sel;
    logic [15:0]   w_div_eff;
    logic [PW-1:0] w_tx_count, w_rx_count;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_push_req, w_rx_ferr;
    logic          w_tx_done, w_rx_done, w_rx_fall, w_tx_o, w_unused;
    logic [7:0]    w_rx_head;

    assign w_unused  = ^{addr_i[31:5], addr_i[1:0], be_i[3], wdata_i[31:18]};
    assign w_sel     = addr_i[4:2];
    assign w_div_eff = (r_div < 16'd4) ? 16'd4 : r_div;

    assign w_tx_count = r_tx_wr - r_tx_rd;
    assign w_rx_count = r_rx_wr - r_rx_rd;
    assign w_tx_full  = (w_tx_count == PW'(FIFO_DEPTH));
    assign w_tx_empty = (w_tx_count == '0);
    assign w_rx_full  = (w_rx_count == PW'(FIFO_DEPTH));
    assign w_rx_empty = (w_rx_count == '0);
    assign w_rx_head  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[AW-1:0]];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_tx_push = we_i && (w_sel == 3'd2) && be_i[0] && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = we_i && (w_sel == 3'd3) && be_i[0] && !w_rx_empty;
    assign w_rx_push = w_rx_push_req && (!w_rx_full || w_rx_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div   <= 16'(DIV_RESET);
            r_tx_en <= 1'b0;
            r_rx_en <= 1'b0;
        end else if (we_i && (w_sel == 3'd0)) begin
            if (be_i[0]) r_div[7:0]  <= wdata_i[7:0];
            if (be_i[1]) r_div[15:8] <= wdata_i[15:8];
            if (be_i[2]) {r_rx_en, r_tx_en} <= wdata_i[17:16];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (we_i && (w_sel == 3'd1) && be_i[0]) begin
                if (wdata_i[5]) r_overrun   <= 1'b0;
                if (wdata_i[6]) r_frame_err <= 1'b0;
            end
            if (w_rx_push_req && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
            if (w_rx_ferr) r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= wdata_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_rx_shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    assign w_tx_done = (r_tx_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_pop) w_tx_state_next = TX_START;
            TX_START: if (w_tx_done) w_tx_state_next = TX_DATA;
            TX_DATA:  if (w_tx_done && (r_tx_bit == 3'd7)) w_tx_state_next = TX_STOP;
            TX_STOP:  if (w_tx_done) w_tx_state_next = w_tx_pop ? TX_START : TX_IDLE;
            default:  w_tx_state_next = TX_IDLE;
        endcase
    end

    // Popping at the last stop cycle chains frames with no idle gap.
    always_comb begin
        w_tx_pop = r_tx_en && !w_tx_empty &&
                   ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_done));
        case (r_tx_state)
            TX_START: w_tx_o = 1'b0;
            TX_DATA:  w_tx_o = r_tx_shift[0];
            default:  w_tx_o = 1'b1;
        endcase
    end
    assign tx_o = w_tx_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rd[AW-1:0]];
            r_tx_div   <= w_div_eff;
            r_tx_cnt   <= w_div_eff - 16'd1;
            r_tx_bit   <= '0;
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_done) begin
                r_tx_cnt <= r_tx_div - 16'd1;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - 16'd1;
            end
        end
    end

    // ---------------- RX path ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_done = (r_rx_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        if (!r_rx_en) begin
            w_rx_state_next = RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE:  if (w_rx_fall) w_rx_state_next = RX_START;
                RX_START: if (w_rx_done) w_rx_state_next = r_rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_rx_done && (r_rx_bit == 3'd7)) w_rx_state_next = RX_STOP;
                RX_STOP:  if (w_rx_done) w_rx_state_next = r_rx_s2 ? RX_IDLE : RX_WAIT;
                RX_WAIT:  if (r_rx_s2) w_rx_state_next = RX_IDLE;
                default:  w_rx_state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rx_push_req = r_rx_en && (r_rx_state == RX_STOP) && w_rx_done && r_rx_s2;
        w_rx_ferr     = r_rx_en && (r_rx_state == RX_STOP) && w_rx_done && !r_rx_s2;
    end

    // Start bit is re-checked half a bit in; later samples land mid-bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (r_rx_state == RX_IDLE) begin
            if (w_rx_fall) begin
                r_rx_div <= w_div_eff;
                r_rx_cnt <= (w_div_eff >> 1) - 16'd1;
                r_rx_bit <= '0;
            end
        end else if (r_rx_state != RX_WAIT) begin
            if (w_rx_done) begin
                r_rx_cnt <= r_rx_div - 16'd1;
                if (r_rx_state == RX_DATA) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        case (w_sel)
            3'd0: rdata_o = {14'b0, r_rx_en, r_tx_en, r_div};
            3'd1: rdata_o = {16'b0, 4'(w_rx_count), 4'(w_tx_count), 1'b0, r_frame_err,
                             r_overrun, (r_tx_state != TX_IDLE), w_rx_empty, w_rx_full,
                             w_tx_empty, w_tx_full};
            3'd3: rdata_o = {23'b0, !w_rx_empty, w_rx_head};
            default: rdata_o = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: register reads and serial TX frames are
// queued as expectations at stimulus time and checked by independent monitors.
module tb_uart_ctrl;
    logic        clk = 1'b0;
    logic        rst, we, tx, rx;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;
    logic        rd_req = 1'b0;
    logic        mon_en = 1'b0;
    int          tb_div = 4;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] rd_exp_q[$];
    logic [31:0] rd_mask_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];

    assign rx = loopback ? tx : rx_drv;

    uart_ctrl #(.FIFO_DEPTH(8), .DIV_RESET(868)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .rx_i(rx), .tx_o(tx)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0; be = 4'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] m, input logic [31:0] e,
                          input string n);
        addr = a;
        rd_exp_q.push_back(e);
        rd_mask_q.push_back(m);
        rd_name_q.push_back(n);
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        wr(32'h8, {24'h0, b}, 4'h1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int d);
        rx_drv = 1'b0;
        idle(d);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            idle(d);
        end
        rx_drv = stop_bit;
        idle(d);
        rx_drv = 1'b1;
    endtask

    task automatic chk1(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", n, got, exp);
        end
    endtask

    // Register-read monitor: one queued expectation per read cycle.
    logic [31:0] rm_e, rm_m;
    string       rm_n;
    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (rd_req) begin
                checks++;
                if (rd_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected: addr=%h rdata=%h", addr, rdata);
                end else begin
                    rm_e = rd_exp_q.pop_front();
                    rm_m = rd_mask_q.pop_front();
                    rm_n = rd_name_q.pop_front();
                    if ((rdata & rm_m) !== rm_e) begin
                        failures++;
                        $display("FAIL %s: addr=%h rdata=%h mask=%h expected=%h",
                                 rm_n, addr, rdata, rm_m, rm_e);
                    end else begin
                        $display("read %s addr=%h rdata=%h ok", rm_n, addr, rdata);
                    end
                end
            end
        end
    end

    // Serial TX monitor: captures every cycle of a frame and compares it with
    // the ideal waveform of the next expected byte.
    int           mon_div;
    logic [159:0] mon_got, mon_exp;
    logic [9:0]   mon_fb;
    logic [7:0]   mon_byte;
    initial begin : tx_mon
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                mon_div = tb_div;
                mon_got = '0;
                mon_got[0] = tx;
                for (int i = 1; i < 10 * mon_div; i++) begin
                    @(negedge clk);
                    mon_got[i] = tx;
                end
                checks++;
                if (tx_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_frame: unexpected frame got=%h", mon_got);
                end else begin
                    mon_byte = tx_q.pop_front();
                    mon_fb = {1'b1, mon_byte, 1'b0};
                    mon_exp = '0;
                    for (int i = 0; i < 10 * mon_div; i++) mon_exp[i] = mon_fb[i / mon_div];
                    if (mon_got !== mon_exp) begin
                        failures++;
                        $display("FAIL tx_frame: byte=%h got=%h expected=%h", mon_byte, mon_got, mon_exp);
                    end else begin
                        $display("tx frame byte=%h ok", mon_byte);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    int busy_cycles;
    initial begin : stim
        rst = 1'b1; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state and decode
        rd_chk(32'h04, 32'hFFFF_FFFF, 32'h0000_000A, "rst_status");
        rd_chk(32'h00, 32'hFFFF_FFFF, 32'h0000_0364, "rst_ctrl");
        chk1("rst_tx_idle", {31'b0, tx}, 32'h1);
        rd_chk(32'h24, 32'hFFFF_FFFF, 32'h0000_000A, "alias_status");
        rd_chk(32'h08, 32'hFFFF_FFFF, 32'h0, "txdata_reads0");
        rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h0, "rxdata_empty");
        wr(32'h14, 32'hFFFF_FFFF, 4'hF);
        rd_chk(32'h14, 32'hFFFF_FFFF, 32'h0, "reg5_reads0");
        rd_chk(32'h00, 32'hFFFF_FFFF, 32'h0000_0364, "reg5_write_ignored");

        // Single TX frame, DIV=4
        wr(32'h00, 32'h0001_0004, 4'h7);
        tb_div = 4;
        send(8'h55);
        @(negedge clk);
        chk1("tx_before_pop", {31'b0, tx}, 32'h1);
        @(negedge clk);
        chk1("tx_start_bit", {31'b0, tx}, 32'h0);
        @(posedge clk); #1;
        rd_chk(32'h04, 32'h10, 32'h10, "tx_busy_mid");
        idle(45);
        rd_chk(32'h04, 32'hFFFF_FFFF, 32'h0000_000A, "status_after_tx");

        // Loopback single byte
        loopback = 1'b1;
        wr(32'h00, 32'h0003_0004, 4'h7);
        send(8'hA3);
        idle(60);
        rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h0000_01A3, "rx_a3");
        rd_chk(32'h04, 32'hF000, 32'h1000, "rx_count1");
        wr(32'h0C, 32'h0, 4'h1);
        rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h0, "rx_after_pop");
        rd_chk(32'h04, 32'h8, 32'h8, "rx_empty_after_pop");

        // Loopback overrun
        for (int i = 1; i <= 9; i++) send(8'(i));
        idle(400);
        rd_chk(32'h04, 32'hF02F, 32'h8026, "rx_overrun_status");
        rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h0000_0101, "rx_head_01");
        wr(32'h04, 32'h20, 4'h1);
        rd_chk(32'h04, 32'h20, 32'h0, "overrun_cleared");
        for (int i = 1; i <= 8; i++) begin
            rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h100 | 32'(i), "rx_drain");
            wr(32'h0C, 32'h0, 4'h1);
        end
        rd_chk(32'h04, 32'hF008, 32'h0008, "rx_drained");

        // Framing error, glitch rejection, then a clean frame at DIV=8
        loopback = 1'b0;
        rx_drv = 1'b1;
        wr(32'h00, 32'h0002_0008, 4'h7);
        idle(4);
        drive_frame(8'h3C, 1'b0, 8);
        idle(20);
        rd_chk(32'h04, 32'hF048, 32'h0048, "frame_err");
        wr(32'h04, 32'h40, 4'h1);
        rd_chk(32'h04, 32'h40, 32'h0, "frame_err_cleared");
        rx_drv = 1'b0;
        idle(3);
        rx_drv = 1'b1;
        idle(20);
        rd_chk(32'h04, 32'hF068, 32'h0008, "glitch_ignored");
        drive_frame(8'h96, 1'b1, 8);
        idle(20);
        rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h0000_0196, "rx_96_after_glitch");
        wr(32'h0C, 32'h0, 4'h1);

        // TX FIFO fill while disabled, then back-to-back burst (DIV=2 clamps to 4)
        loopback = 1'b1;
        wr(32'h00, 32'h0002_0002, 4'h7);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(8'(8'h10 + i));
            wr(32'h08, 32'h10 + 32'(i), 4'h1);
        end
        rd_chk(32'h04, 32'h0F03, 32'h0801, "tx_full");
        rd_chk(32'h00, 32'hFFFF_FFFF, 32'h0002_0002, "ctrl_raw_div");
        tb_div = 4;
        wr(32'h00, 32'h0003_0002, 4'h7);
        addr = 32'h04;
        busy_cycles = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (rdata[4]) busy_cycles++;
            else if (busy_cycles != 0) break;
        end
        @(posedge clk); #1;
        chk1("burst_busy_cycles", 32'(busy_cycles), 32'd320);
        idle(10);
        rd_chk(32'h04, 32'hFF0F, 32'h8006, "burst_done_status");
        for (int i = 0; i < 8; i++) begin
            rd_chk(32'h0C, 32'hFFFF_FFFF, 32'h110 + 32'(i), "burst_rx");
            wr(32'h0C, 32'h0, 4'h1);
        end
        rd_chk(32'h04, 32'h8, 32'h8, "burst_rx_empty");

        idle(50);
        chk1("tx_pending", 32'(tx_q.size()), 32'd0);
        chk1("rd_pending", 32'(rd_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
